rv32i_wb_sram_slave: RTL and testbench
======================================

// Module: rv32i_wb_sram_slave
// PURPOSE
//   Wishbone (pipelined, single-outstanding) responder fronting an on-chip
//   word-addressed SRAM. It is the target of the MEM-stage data adapter and
//   the fetch adapter on the core's Wishbone bus. It decodes a base/size
//   window and inserts programmable wait states. Accesses that are out of
//   window or misaligned complete with wb_err_o.
// PARAMETERS
//   ADDR_WIDTH   WB_ADDR_WIDTH (32)  byte-address width
//   DATA_WIDTH   WB_DATA_WIDTH (32)  data width; DATA_WIDTH/8 select lanes
//   DEPTH_WORDS  1024                SRAM depth in words; power of 2, >=2
//   BASE_ADDR    32'h0000_0000       window base; aligned to DEPTH_WORDS*4
//   WAIT_STATES  1                   extra cycles between accept and ack (0..15)
// PORTS
//   clk_i       in   1             clock; all logic on posedge
//   rst_ni      in   1             reset, synchronous, active-low
//   wb_cyc_i    in   1             bus cycle active
//   wb_stb_i    in   1             request strobe
//   wb_we_i     in   1             1 = write, 0 = read
//   wb_sel_i    in   DATA_WIDTH/8  byte-lane enables (writes only)
//   wb_adr_i    in   ADDR_WIDTH    byte address
//   wb_dat_i    in   DATA_WIDTH    write data
//   wb_dat_o    out  DATA_WIDTH    read data, valid only while wb_ack_o=1
//   wb_ack_o    out  1             one-cycle successful-completion pulse
//   wb_err_o    out  1             one-cycle error-completion pulse
//   wb_stall_o  out  1             1 = request not accepted this cycle
// BEHAVIOUR
//   Reset (rst_ni=0 at a posedge): state=IDLE, cnt=0, wb_ack_o=0,
//     wb_err_o=0, wb_dat_o=0, wb_stall_o=0. SRAM contents are not reset.
//   FSM states: IDLE, WAIT, RESP. wb_stall_o = (state != IDLE), decoded
//     combinationally from the state register.
//   Accept: IDLE && wb_cyc_i && wb_stb_i. At the accept edge, latch we, sel,
//     adr, dat and the decode result:
//     hit = (adr - BASE_ADDR) < DEPTH_WORDS*4 && adr[1:0]==2'b00.
//     Word index = (adr - BASE_ADDR) >> 2.
//   Accept edge with WAIT_STATES==0 -> RESP. Otherwise -> WAIT, cnt=WAIT_STATES-1.
//   In WAIT:
//     - cnt!=0 -> cnt decrements.
//     - cnt==0 -> RESP.
//   Abort: wb_cyc_i=0 in any WAIT cycle -> IDLE next edge. No ack/err, no
//     SRAM write. Abort takes priority over the cnt==0 transition.
//   Edge entering RESP:
//     - hit && we: write each byte lane b where sel[b]=1; other lanes are kept.
//     - hit && !we: wb_dat_o <= mem[index].
//     - !hit: no write, wb_dat_o <= 0.
//   In RESP (exactly one cycle, then always IDLE):
//     - hit: wb_ack_o=1. Otherwise wb_err_o=1.
//     - ack and err are never both 1. wb_dat_o returns to 0 on the following edge.
//   Latency: accept in cycle N -> ack/err in cycle N+1+WAIT_STATES.
//     Back-to-back throughput is one access per 2+WAIT_STATES cycles.
//   The next request can be accepted in the cycle after RESP. A stb held
//     through RESP is not re-accepted, because stall=1 in RESP.
//   Write with sel=0 acks normally and modifies nothing.
//   Address wrap: (adr - BASE_ADDR) is an unsigned ADDR_WIDTH subtraction, so
//     adr < BASE_ADDR wraps large and yields err.
//   wb_stb_i without wb_cyc_i is ignored in IDLE.
//   Reset mid-transfer (in WAIT or RESP): returns to IDLE. Any pending write
//     is dropped, and no ack/err is emitted after reset.
//   Assertions: !(wb_ack_o && wb_err_o); wb_ack_o|wb_err_o |-> state==RESP.
// TESTING
//   1 W=1: write 0xDEADBEEF, sel=4'hF, @BASE+0x10; read it back -> ack in
//     cycle N+2 of each access, dat_o=0xDEADBEEF.
//   2 Byte lanes: after test 1, write 0x000000AA with sel=4'b0001, then read
//     -> 0xDEADBEAA; sel=4'b0000 write leaves 0xDEADBEAA.
//   3 Errors: read BASE+DEPTH_WORDS*4, read BASE+0x2, and (BASE!=0) read
//     BASE-4 -> err pulse, ack=0, dat_o=0; follow-up read of BASE+0x10
//     still returns its written value.
//   4 Abort: write 0x12345678 to BASE+0x20 with W=3, drop cyc 1 cycle after
//     accept -> no ack/err, IDLE next cycle; read BASE+0x20 -> old value.
//   5 W=0 back-to-back reads with stb held high -> ack every 2nd cycle,
//     stall=1 exactly in each RESP cycle, no duplicate accepts.
//   6 Reset in WAIT (W=4, write pending) -> outputs 0 after edge, no write,
//     no ack; next access behaves normally.

Source files
------------

// File: rtl/rv32i_wb_sram_slave.sv
// Wishbone pipelined single-outstanding responder in front of a word-addressed
// on-chip SRAM. Decodes a base/size window, inserts WAIT_STATES wait cycles and
// completes out-of-window or misaligned accesses with an error pulse.
module rv32i_wb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_stall_o
);

    localparam int         SEL_W    = DATA_WIDTH / 8;
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [3:0] cnt;

    // Request captured at the accept edge
    logic                  we_p0;
    logic [SEL_W-1:0]      sel_p0;
    logic [DATA_WIDTH-1:0] dat_p0;
    logic [IDX_W-1:0]      idx_p0;
    logic                  hit_p0;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Window decode on the live bus address. The base is aligned to the
    // window size, so the low two offset bits equal the address byte offset.
    logic [ADDR_WIDTH-1:0] offset;
    logic                  hit_in;
    logic                  accept;
    logic                  enter_resp;

    assign offset = wb_adr_i - BASE_ADDR;
    assign hit_in = (offset[ADDR_WIDTH-1:IDX_W+2] == '0) && (offset[1:0] == 2'b00);
    assign accept = (state == S_IDLE) && wb_cyc_i && wb_stb_i;

    // With zero wait states RESP is entered on the accept edge itself, before
    // the captured copy exists, so the live bus fields are used in IDLE.
    logic                  req_we;
    logic [SEL_W-1:0]      req_sel;
    logic [DATA_WIDTH-1:0] req_dat;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_hit;

    assign req_we  = (state == S_IDLE) ? wb_we_i              : we_p0;
    assign req_sel = (state == S_IDLE) ? wb_sel_i             : sel_p0;
    assign req_dat = (state == S_IDLE) ? wb_dat_i             : dat_p0;
    assign req_idx = (state == S_IDLE) ? offset[IDX_W+1:2]    : idx_p0;
    assign req_hit = (state == S_IDLE) ? hit_in               : hit_p0;

    // RESP always exits to IDLE, so a RESP next-state marks the entry edge.
    assign enter_resp = (state_nxt == S_RESP);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a dropped cycle in WAIT wins over the count expiring
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Completion and stall outputs decoded from the state register
    always_comb begin
        wb_stall_o = (state != S_IDLE);
        wb_ack_o   = 1'b0;
        wb_err_o   = 1'b0;
        if (state == S_RESP) begin
            wb_ack_o = hit_p0;
            wb_err_o = !hit_p0;
        end
    end

    // Wait-state counter, loaded on accept and run down while waiting
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Capture the request fields and decode result at the accept edge
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_p0  <= wb_we_i;
            sel_p0 <= wb_sel_i;
            dat_p0 <= wb_dat_i;
            idx_p0 <= offset[IDX_W+1:2];
            hit_p0 <= hit_in;
        end
    end

    // Byte-lane SRAM write on the edge entering RESP; reset drops it
    always_ff @(posedge clk_i) begin
        if (rst_ni && enter_resp && req_hit && req_we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (req_sel[b]) begin
                    mem[req_idx][b*8 +: 8] <= req_dat[b*8 +: 8];
                end
            end
        end
    end

    // Read data is presented only during the RESP cycle, zero otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_dat_o <= '0;
        end else if (enter_resp && req_hit && !req_we) begin
            wb_dat_o <= mem[req_idx];
        end else begin
            wb_dat_o <= '0;
        end
    end

    a_ack_err_exclusive: assert property (@(posedge clk_i) !(wb_ack_o && wb_err_o));
    a_done_only_in_resp: assert property (@(posedge clk_i)
        (wb_ack_o || wb_err_o) |-> (state == S_RESP));

endmodule

// File: tb/tb_rv32i_wb_sram_slave.sv
// Randomized bench for rv32i_wb_sram_slave: two instances (3 wait states with a
// nonzero base, and zero wait states at base 0) checked against a word-array
// memory model and the cycle timing of the bus protocol.
module tb_rv32i_wb_sram_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE0 = 32'h0000_2000;
    localparam logic [31:0] BASE1 = 32'h0000_0000;
    localparam int          W0    = 3;
    localparam int          W1    = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cyc, stb, we, ack, err, stall;
    logic [3:0]  sel  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [2][DEPTH];

    always #5 clk = ~clk;

    rv32i_wb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE0), .WAIT_STATES(W0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_stall_o(stall[0])
    );

    rv32i_wb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE1), .WAIT_STATES(W1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_stall_o(stall[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int w_of(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic bit is_hit(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(k);
        return (off < 32'(DEPTH * 4)) && (a[1:0] == 2'b00);
    endfunction

    function automatic int idx_of(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = (a - base_of(k)) >> 2;
        return int'(off[5:0]);
    endfunction

    // One bus access, entered and left at a negedge with the DUT idle.
    // abort_at / rst_at (1..W) drop cyc or assert reset in that WAIT cycle.
    task automatic xfer(input int k, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input int abort_at, input int rst_at);
        int          ws;
        bit          h;
        logic [31:0] exp_rd;
        ws     = w_of(k);
        h      = is_hit(k, a);
        exp_rd = h ? mem_m[k][idx_of(k, a)] : 32'd0;
        chk("idle_stall", 32'(stall[k]), 32'd0);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wdat[k] = d;
        for (int c = 1; c <= 1 + ws; c++) begin
            @(negedge clk);
            if (!hold) stb[k] = 1'b0;
            chk("busy_stall", 32'(stall[k]), 32'd1);
            if (c == abort_at) begin
                cyc[k] = 1'b0;
                @(negedge clk);
                chk("abort_stall", 32'(stall[k]), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    chk("abort_no_done", {30'd0, ack[k], err[k]}, 32'd0);
                    @(negedge clk);
                end
                return;
            end
            if (c == rst_at) begin
                rst_n = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
                @(negedge clk);
                chk("rst_outputs", {29'd0, ack[k], err[k], stall[k]}, 32'd0);
                chk("rst_dat", rdat[k], 32'd0);
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("rst_no_done", {30'd0, ack[k], err[k]}, 32'd0);
                end
                return;
            end
            if (c < 1 + ws) begin
                chk("wait_no_done", {30'd0, ack[k], err[k]}, 32'd0);
            end else begin
                chk("resp_ack", 32'(ack[k]), 32'(h));
                chk("resp_err", 32'(err[k]), 32'(!h));
                if (!h || !w) chk("resp_dat", rdat[k], exp_rd);
            end
        end
        if (h && w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mem_m[k][idx_of(k, a)][b*8 +: 8] = d[b*8 +: 8];
        end
        @(negedge clk);
        chk("after_idle", {29'd0, ack[k], err[k], stall[k]}, 32'd0);
        chk("after_dat", rdat[k], 32'd0);
        if (!hold) begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        logic [31:0] b;
        b = base_of(k);
        case ($urandom_range(0, 9))
            0:       return b + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            1:       return b + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 100));
            2:       return b - 32'(4 * $urandom_range(1, 100));
            3:       return $urandom;
            default: return b + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; cyc = '0; stb = '0; we = '0;
        for (int k = 0; k < 2; k++) begin
            sel[k] = '0; adr[k] = '0; wdat[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ctl", {29'd0, ack[k], err[k], stall[k]}, 32'd0);
            chk("reset_dat", rdat[k], 32'd0);
        end
        rst_n = 1'b1;

        // Give every word a known value
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                xfer(k, 1'b1, 4'hF, base_of(k) + 32'(4 * i), $urandom, 1'b0, 0, 0);

        for (int k = 0; k < 2; k++) begin
            xfer(k, 1'b1, 4'hF, base_of(k) + 32'h10, 32'hDEAD_BEEF, 1'b0, 0, 0);
            xfer(k, 1'b0, 4'hF, base_of(k) + 32'h10, 32'h0, 1'b0, 0, 0);
            xfer(k, 1'b1, 4'b0001, base_of(k) + 32'h10, 32'h0000_00AA, 1'b0, 0, 0);
            xfer(k, 1'b0, 4'hF, base_of(k) + 32'h10, 32'h0, 1'b0, 0, 0);
            xfer(k, 1'b1, 4'b0000, base_of(k) + 32'h10, 32'h5555_5555, 1'b0, 0, 0);
            xfer(k, 1'b0, 4'hF, base_of(k) + 32'h10, 32'h0, 1'b0, 0, 0);
            chk("lane_model", mem_m[k][4], 32'hDEAD_BEAA);
            xfer(k, 1'b0, 4'hF, base_of(k) + 32'(DEPTH * 4), 32'h0, 1'b0, 0, 0);
            xfer(k, 1'b0, 4'hF, base_of(k) + 32'h2, 32'h0, 1'b0, 0, 0);
            xfer(k, 1'b0, 4'hF, base_of(k) - 32'h4, 32'h0, 1'b0, 0, 0);
            xfer(k, 1'b0, 4'hF, base_of(k) + 32'h10, 32'h0, 1'b0, 0, 0);
        end

        // Abort and reset while a write is waiting
        xfer(0, 1'b1, 4'hF, BASE0 + 32'h20, 32'h1234_5678, 1'b0, 1, 0);
        xfer(0, 1'b0, 4'hF, BASE0 + 32'h20, 32'h0, 1'b0, 0, 0);
        xfer(0, 1'b1, 4'hF, BASE0 + 32'h24, 32'hCAFE_F00D, 1'b0, 0, W0);
        xfer(0, 1'b0, 4'hF, BASE0 + 32'h24, 32'h0, 1'b0, 0, 0);

        // Zero-wait back-to-back reads with the strobe held high throughout
        for (int i = 0; i < 10; i++)
            xfer(1, 1'b0, 4'hF, BASE1 + 32'(4 * i), 32'h0, 1'b1, 0, 0);
        cyc[1] = 1'b0; stb[1] = 1'b0;

        // Strobe without cycle is ignored
        stb[0] = 1'b1; adr[0] = BASE0;
        @(negedge clk);
        chk("stb_no_cyc", {30'd0, stall[0], ack[0]}, 32'd0);
        stb[0] = 1'b0;

        for (int n = 0; n < 400; n++) begin
            int          k;
            int          ab;
            int          rs;
            logic [31:0] a;
            k  = int'($urandom_range(0, 1));
            a  = rand_addr(k);
            ab = 0;
            rs = 0;
            if (k == 0 && $urandom_range(0, 9) == 0) ab = int'($urandom_range(1, W0));
            else if (k == 0 && $urandom_range(0, 14) == 0) rs = int'($urandom_range(1, W0));
            xfer(k, 1'($urandom), 4'($urandom), a, $urandom, 1'b0, ab, rs);
        end

        // Final sweep: every word matches the model
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                xfer(k, 1'b0, 4'hF, base_of(k) + 32'(4 * i), 32'h0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
